alureg_seq: RTL and testbench
=============================

# alureg_seq

Instruction sequencer directly upstream of the ALU/register-file datapath. Accepts 16-bit instruction words on a valid/ready stream, decodes them, and drives the datapath control inputs for one execute cycle per instruction. The controls are op, read/write addresses, wr, sel and d_in. It captures the datapath carry into a sticky flag and counts retired instructions.

## Interface
- No parameters; data width 16, register address width 3, op width 2 (fixed by the datapath).
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- instr_valid  input  1  upstream word valid
- instr  input  16  instruction or immediate data word
- instr_ready  output  1  sequencer accepts a word when instr_valid && instr_ready
- cout_in  input  1  carry from the datapath ALU (same cycle as op)
- op  output  2  ALU operation to the datapath
- rd_addr_a  output  3  datapath read port A address
- rd_addr_b  output  3  datapath read port B address
- wr_addr  output  3  datapath write address
- wr  output  1  datapath register write enable
- sel  output  1  write-data select: 1 = ALU result, 0 = d_in
- d_in  output  16  immediate data for the register file
- carry_flag  output  1  carry captured by the last ALU/CMP instruction
- busy  output  1  high in any state other than IDLE
- retired  output  16  count of completed instructions

## Operation
- Instruction format: [15:14] class, [13:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored.
- Class 00 ALU: rd <= ra op rb; wr=1, sel=1; carry_flag <= cout_in.
- Class 01 LOAD: the next accepted word is immediate data; rd <= data; wr=1, sel=0.
- Class 10 NOP: one execute cycle with wr=0; carry_flag unchanged.
- Class 11 CMP: same as ALU but wr=0; carry_flag <= cout_in.
- FSM states: IDLE, EXEC, LDWAIT, LDWR.
  - IDLE: instr_ready=1. Accepting class 00/10/11 latches the word into ireg and goes to EXEC. Accepting class 01 latches it and goes to LDWAIT.
  - EXEC: instr_ready=0. Drives op/rd_addr_a/rd_addr_b/wr_addr from ireg, sets sel=1, and sets wr per class. Goes to IDLE next cycle; retired increments.
  - LDWAIT: instr_ready=1. Waits indefinitely for instr_valid. On acceptance, the word is latched into the data register and the FSM goes to LDWR.
  - LDWR: instr_ready=0. Drives d_in=data register, wr_addr=ireg rd, sel=0, wr=1. Goes to IDLE next cycle; retired increments.
- Outside EXEC/LDWR: wr=0, sel=0, op=0, all addresses 0. d_in always reflects the data register (holds its last value).
- retired wraps 0xFFFF -> 0x0000 without any flag.
- ireg and the data register update only on a handshake; instr is ignored when instr_ready=0.

## Timing
- Reset values: FSM=IDLE, ireg=0, data=0, op=0, all addresses=0, wr=0, sel=0, d_in=0, carry_flag=0, retired=0, busy=0.
- instr_ready=0 while reset is asserted; it becomes 1 in the first cycle after deassertion.
- ALU/NOP/CMP: handshake at edge N, EXEC during cycle N+1, register write and carry capture at edge N+2. Throughput is 1 instruction per 2 cycles.
- LOAD: opcode handshake at edge N, LDWAIT from cycle N+1. Data handshake at edge M (M >= N+1), LDWR during cycle M+1, register write at edge M+2.
- carry_flag is sampled from cout_in only at the end of EXEC for class 00/11.
- retired increments on the same edge as the datapath write.
- Reset asserted mid-instruction (any state) aborts it: no write, no retire, and all outputs return to reset values immediately (asynchronous).
- Back-to-back valid words are accepted exactly at IDLE/LDWAIT cycles; no word is dropped or duplicated.

## Test plan
- Reset check: assert reset with instr_valid=1 -> all outputs 0 and instr_ready=0. After release -> instr_ready=1 next cycle.
- LOAD: send 0x4200 then 0x00FF -> one LDWR cycle with wr=1, sel=0, wr_addr=1, d_in=0x00FF; retired=1.
- ALU: send 0x0650 -> one EXEC cycle with op=0, rd_addr_a=1, rd_addr_b=2, wr_addr=3, wr=1, sel=1; instr_ready=0 in that cycle.
- CMP: send 0xC048 with cout_in forced to 1 during EXEC -> wr=0 throughout and carry_flag=1 afterwards. A following NOP 0x8000 leaves carry_flag=1.
- Stall: send LOAD 0x4E00, hold instr_valid low for 5 cycles, then send 0x1234 -> busy=1 and wr=0 throughout the stall. Then one write occurs with wr_addr=7, d_in=0x1234.
- Wrap and abort:
  - Preload retired to 0xFFFF via 65535 NOPs, then 1 more NOP -> retired=0x0000.
  - Assert reset during LDWAIT -> no write occurs, and the next word is decoded as an instruction.

Source files
------------

// File: rtl/alureg_seq.sv
// rtl/alureg_seq.sv - instruction sequencer driving ALU/register-file datapath controls
`timescale 1ns/1ps
module alureg_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        cout_in,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic        wr,
    output logic        sel,
    output logic [15:0] d_in,
    output logic        carry_flag,
    output logic        busy,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        LDWAIT = 2'd2,
        LDWR   = 2'd3
    } state_t;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LOAD = 2'b01;
    localparam logic [1:0] CLS_CMP  = 2'b11;

    state_t      state_q;
    state_t      state_d;
    // bits [2:0] of an instruction carry no meaning, so only [15:3] are kept
    logic [15:3] ireg;
    logic [15:0] data_reg;
    logic        ready_state;
    logic        take;
    logic        retire;
    logic [1:0]  cls;

    assign cls         = ireg[15:14];
    assign instr_ready = ready_state & ~reset;
    assign take        = instr_valid & instr_ready;
    assign retire      = (state_q == EXEC) || (state_q == LDWR);
    assign busy        = (state_q != IDLE);
    assign d_in        = data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_state = 1'b0;
        op          = 2'b00;
        rd_addr_a   = 3'd0;
        rd_addr_b   = 3'd0;
        wr_addr     = 3'd0;
        wr          = 1'b0;
        sel         = 1'b0;
        case (state_q)
            IDLE: begin
                ready_state = 1'b1;
                if (take) begin
                    state_d = (instr[15:14] == CLS_LOAD) ? LDWAIT : EXEC;
                end
            end
            EXEC: begin
                op        = ireg[13:12];
                wr_addr   = ireg[11:9];
                rd_addr_a = ireg[8:6];
                rd_addr_b = ireg[5:3];
                sel       = 1'b1;
                wr        = (cls == CLS_ALU);
                state_d   = IDLE;
            end
            LDWAIT: begin
                ready_state = 1'b1;
                if (take) begin
                    state_d = LDWR;
                end
            end
            LDWR: begin
                wr_addr = ireg[11:9];
                wr      = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word capture happens only on a handshake; the state decides where it lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ireg       <= '0;
            data_reg   <= '0;
            carry_flag <= 1'b0;
            retired    <= '0;
        end else begin
            if (take && state_q == IDLE) begin
                ireg <= instr[15:3];
            end
            if (take && state_q == LDWAIT) begin
                data_reg <= instr;
            end
            if (state_q == EXEC && (cls == CLS_ALU || cls == CLS_CMP)) begin
                carry_flag <= cout_in;
            end
            if (retire) begin
                retired <= retired + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alureg_seq.sv
// tb/tb_alureg_seq.sv - directed self-checking bench for alureg_seq
`timescale 1ns/1ps
module tb_alureg_seq;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        cout_in;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic        wr;
    logic        sel;
    logic [15:0] d_in;
    logic        carry_flag;
    logic        busy;
    logic [15:0] retired;

    int checks;
    int passed;

    alureg_seq dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .cout_in     (cout_in),
        .op          (op),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .wr_addr     (wr_addr),
        .wr          (wr),
        .sel         (sel),
        .d_in        (d_in),
        .carry_flag  (carry_flag),
        .busy        (busy),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'h4200;
        cout_in     = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (instr_ready !== 1'b0) $display("FAIL reset_ready got=%h exp=0", instr_ready); else passed++;
        checks++; if ({op, rd_addr_a, rd_addr_b, wr_addr, wr, sel} !== 13'd0) $display("FAIL reset_ctrl got=%h exp=0", {op, rd_addr_a, rd_addr_b, wr_addr, wr, sel}); else passed++;
        checks++; if ({d_in, retired, carry_flag, busy} !== 34'd0) $display("FAIL reset_state got=%h exp=0", {d_in, retired, carry_flag, busy}); else passed++;
        instr_valid = 1'b0;
        cout_in     = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) $display("FAIL reset_release_ready got=%h exp=1", instr_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy got=%h exp=0", busy); else passed++;
    endtask

    task automatic test_load();
        instr_valid = 1'b1;
        instr       = 16'h4200;
        @(negedge clk);
        checks++; if ({busy, instr_ready, wr} !== 3'b110) $display("FAIL load_wait got=%b exp=110", {busy, instr_ready, wr}); else passed++;
        instr = 16'h00FF;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({wr, sel, wr_addr} !== 5'b10_001) $display("FAIL load_ctrl got=%b exp=10001", {wr, sel, wr_addr}); else passed++;
        checks++; if (d_in !== 16'h00FF) $display("FAIL load_d_in got=%h exp=00ff", d_in); else passed++;
        checks++; if (instr_ready !== 1'b0) $display("FAIL load_ldwr_ready got=%h exp=0", instr_ready); else passed++;
        @(negedge clk);
        checks++; if (retired !== 16'd1) $display("FAIL load_retired got=%h exp=0001", retired); else passed++;
        checks++; if ({wr, busy} !== 2'b00) $display("FAIL load_after got=%b exp=00", {wr, busy}); else passed++;
    endtask

    task automatic test_alu();
        instr_valid = 1'b1;
        instr       = 16'h0650;
        cout_in     = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({op, rd_addr_a, rd_addr_b, wr_addr} !== {2'd0, 3'd1, 3'd2, 3'd3}) $display("FAIL alu_addr got=%h exp=%h", {op, rd_addr_a, rd_addr_b, wr_addr}, {2'd0, 3'd1, 3'd2, 3'd3}); else passed++;
        checks++; if ({wr, sel, instr_ready, busy} !== 4'b1101) $display("FAIL alu_ctrl got=%b exp=1101", {wr, sel, instr_ready, busy}); else passed++;
        checks++; if (d_in !== 16'h00FF) $display("FAIL alu_d_in_hold got=%h exp=00ff", d_in); else passed++;
        @(negedge clk);
        checks++; if ({retired, carry_flag} !== {16'd2, 1'b0}) $display("FAIL alu_after got=%h exp=%h", {retired, carry_flag}, {16'd2, 1'b0}); else passed++;
    endtask

    task automatic test_cmp_nop();
        instr_valid = 1'b1;
        instr       = 16'hC048;
        @(negedge clk);
        instr_valid = 1'b0;
        cout_in     = 1'b1;
        checks++; if ({wr, sel, rd_addr_a, rd_addr_b} !== {1'b0, 1'b1, 3'd1, 3'd1}) $display("FAIL cmp_ctrl got=%h exp=%h", {wr, sel, rd_addr_a, rd_addr_b}, {1'b0, 1'b1, 3'd1, 3'd1}); else passed++;
        @(negedge clk);
        cout_in = 1'b0;
        checks++; if ({carry_flag, retired} !== {1'b1, 16'd3}) $display("FAIL cmp_after got=%h exp=%h", {carry_flag, retired}, {1'b1, 16'd3}); else passed++;
        instr_valid = 1'b1;
        instr       = 16'h8000;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({wr, busy} !== 2'b01) $display("FAIL nop_ctrl got=%b exp=01", {wr, busy}); else passed++;
        @(negedge clk);
        checks++; if ({carry_flag, retired} !== {1'b1, 16'd4}) $display("FAIL nop_after got=%h exp=%h", {carry_flag, retired}, {1'b1, 16'd4}); else passed++;
    endtask

    task automatic test_stall();
        int bad;
        bad         = 0;
        instr_valid = 1'b1;
        instr       = 16'h4E00;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            if ({busy, wr, instr_ready} !== 3'b101) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); else passed++;
        checks++; if (d_in !== 16'h00FF) $display("FAIL stall_data_hold got=%h exp=00ff", d_in); else passed++;
        instr_valid = 1'b1;
        instr       = 16'h1234;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({wr, sel, wr_addr, d_in} !== {1'b1, 1'b0, 3'd7, 16'h1234}) $display("FAIL stall_write got=%h exp=%h", {wr, sel, wr_addr, d_in}, {1'b1, 1'b0, 3'd7, 16'h1234}); else passed++;
        @(negedge clk);
        checks++; if (retired !== 16'd5) $display("FAIL stall_retired got=%h exp=0005", retired); else passed++;
    endtask

    task automatic test_back_to_back();
        instr_valid = 1'b1;
        instr       = 16'h2E38;
        cout_in     = 1'b0;
        @(negedge clk);
        checks++; if ({op, wr_addr, rd_addr_a, rd_addr_b} !== {2'd2, 3'd7, 3'd0, 3'd7}) $display("FAIL b2b_a got=%h exp=%h", {op, wr_addr, rd_addr_a, rd_addr_b}, {2'd2, 3'd7, 3'd0, 3'd7}); else passed++;
        instr = 16'h3252;
        @(negedge clk);
        checks++; if ({busy, instr_ready, carry_flag} !== 3'b010) $display("FAIL b2b_idle got=%b exp=010", {busy, instr_ready, carry_flag}); else passed++;
        @(negedge clk);
        instr_valid = 1'b0;
        cout_in     = 1'b1;
        checks++; if ({op, wr_addr, rd_addr_a, rd_addr_b, wr} !== {2'd3, 3'd1, 3'd1, 3'd2, 1'b1}) $display("FAIL b2b_b got=%h exp=%h", {op, wr_addr, rd_addr_a, rd_addr_b, wr}, {2'd3, 3'd1, 3'd1, 3'd2, 1'b1}); else passed++;
        @(negedge clk);
        cout_in = 1'b0;
        checks++; if ({retired, carry_flag} !== {16'd7, 1'b1}) $display("FAIL b2b_after got=%h exp=%h", {retired, carry_flag}, {16'd7, 1'b1}); else passed++;
        @(negedge clk);
        checks++; if ({retired, busy} !== {16'd7, 1'b0}) $display("FAIL b2b_no_dup got=%h exp=%h", {retired, busy}, {16'd7, 1'b0}); else passed++;
    endtask

    task automatic test_wrap();
        force dut.retired = 16'hFFFE;
        #1;
        release dut.retired;
        for (int i = 0; i < 2; i++) begin
            instr_valid = 1'b1;
            instr       = 16'h8000;
            @(negedge clk);
            instr_valid = 1'b0;
            @(negedge clk);
            if (i == 0) begin
                checks++; if (retired !== 16'hFFFF) $display("FAIL wrap_max got=%h exp=ffff", retired); else passed++;
            end else begin
                checks++; if (retired !== 16'h0000) $display("FAIL wrap_zero got=%h exp=0000", retired); else passed++;
            end
        end
    endtask

    task automatic test_abort();
        instr_valid = 1'b1;
        instr       = 16'h4A00;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({busy, instr_ready} !== 2'b11) $display("FAIL abort_ldwait got=%b exp=11", {busy, instr_ready}); else passed++;
        #1;
        reset = 1'b1;
        #1;
        checks++; if ({busy, instr_ready, wr, sel, wr_addr} !== 7'd0) $display("FAIL abort_async got=%b exp=0", {busy, instr_ready, wr, sel, wr_addr}); else passed++;
        checks++; if ({retired, d_in, carry_flag} !== 33'd0) $display("FAIL abort_state got=%h exp=0", {retired, d_in, carry_flag}); else passed++;
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b1;
        instr       = 16'h0650;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({wr, sel, wr_addr, rd_addr_a, rd_addr_b} !== {1'b1, 1'b1, 3'd3, 3'd1, 3'd2}) $display("FAIL abort_decode got=%h exp=%h", {wr, sel, wr_addr, rd_addr_a, rd_addr_b}, {1'b1, 1'b1, 3'd3, 3'd1, 3'd2}); else passed++;
        checks++; if (d_in !== 16'h0000) $display("FAIL abort_no_data got=%h exp=0000", d_in); else passed++;
        @(negedge clk);
        checks++; if (retired !== 16'd1) $display("FAIL abort_retired got=%h exp=0001", retired); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_load();
        test_alu();
        test_cmp_nop();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
